// File: rtl/omem_potential_store.sv
// OMEM potential store: per-SPE FIFO-ordered membrane-potential memory.
// Writes from the current timestep become the read-back set for the next one.
module omem_potential_store #(
  parameter int NUM_SPE       = 5,
  parameter int DEPTH         = 128,
  parameter int SUM_WIDTH     = 13,
  parameter int SPE_ADDR_BASE = 5,
  parameter int OP_PREV_POT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_dest,
  output logic [3:0]  out_opcode,
  output logic [24:0] out_data,
  input  logic        ts_done,
  output logic [15:0] spike_cnt,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_bad_id
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = $clog2(NUM_SPE * DEPTH);

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t state, state_nxt;

  logic [PW-1:0]        wr_ptr     [NUM_SPE];
  logic [PW-1:0]        rd_ptr     [NUM_SPE];
  logic [PW-1:0]        prev_count [NUM_SPE];
  logic [SUM_WIDTH-1:0] mem        [NUM_SPE*DEPTH];

  logic [2:0]    in_id;
  logic          in_rw, accept, id_ok, acc_wr, acc_rd, acc_bad;
  logic [PW-1:0] cur_wr, cur_rd, cur_prev;
  logic          wr_full, do_store, rd_under;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [2:0]           rd_id_p0;
  logic [AW-1:0]        rd_addr_p0;
  logic                 under_p0;
  logic [SUM_WIDTH-1:0] rd_pot_p1;

  // Upper payload bits carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^in_data[24:SUM_WIDTH+1];

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic b);
    if (b && (c != 16'hFFFF)) return c + 16'd1;
    return c;
  endfunction

  assign in_id    = in_opcode[3:1];
  assign in_rw    = in_opcode[0];
  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign id_ok    = int'(in_id) < NUM_SPE;
  assign acc_wr   = accept && id_ok && !in_rw;
  assign acc_rd   = accept && id_ok && in_rw;
  assign acc_bad  = accept && !id_ok;

  // Select the addressed SPE's pointers without indexing past NUM_SPE.
  always_comb begin
    cur_wr   = '0;
    cur_rd   = '0;
    cur_prev = '0;
    for (int i = 0; i < NUM_SPE; i++) begin
      if (int'(in_id) == i) begin
        cur_wr   = wr_ptr[i];
        cur_rd   = rd_ptr[i];
        cur_prev = prev_count[i];
      end
    end
  end

  assign wr_full  = (cur_wr == PW'(DEPTH));
  assign do_store = acc_wr && !wr_full;
  assign rd_under = (cur_rd >= cur_prev);
  assign wr_addr  = AW'(int'(in_id) * DEPTH + int'(cur_wr[IW-1:0]));
  assign rd_addr  = AW'(int'(in_id) * DEPTH + int'(cur_rd[IW-1:0]));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a read occupies the block until its response is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_rd) state_nxt = RD;
      RD:      state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, spike counter and sticky errors; ts_done rolls the timestep over.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPE; i++) begin
        wr_ptr[i]     <= '0;
        rd_ptr[i]     <= '0;
        prev_count[i] <= '0;
      end
      spike_cnt     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_bad_id    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SPE; i++) begin
        if (ts_done) begin
          prev_count[i] <= wr_ptr[i];
          wr_ptr[i]     <= '0;
          rd_ptr[i]     <= '0;
        end else if (int'(in_id) == i) begin
          if (do_store) wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (acc_rd && (rd_ptr[i] != PW'(DEPTH))) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
      end
      if (ts_done)       spike_cnt <= '0;
      else if (do_store) spike_cnt <= sat_inc(spike_cnt, in_data[0]);
      if (acc_wr && wr_full)  err_overflow  <= 1'b1;
      if (acc_rd && rd_under) err_underflow <= 1'b1;
      if (acc_bad)            err_bad_id    <= 1'b1;
    end
  end

  // p0: latch the read request at accept.
  always_ff @(posedge clk) begin
    if (acc_rd) begin
      rd_id_p0   <= in_id;
      rd_addr_p0 <= rd_addr;
      under_p0   <= rd_under;
    end
  end

  // Memory port: store on write accept; p1 synchronous read during RD.
  always_ff @(posedge clk) begin
    if (do_store) mem[wr_addr] <= in_data[SUM_WIDTH:1];
    if (state == RD) rd_pot_p1 <= mem[rd_addr_p0];
  end

  assign out_valid  = (state == RESP);
  assign out_dest   = out_valid ? 4'(SPE_ADDR_BASE + int'(rd_id_p0)) : 4'd0;
  assign out_opcode = out_valid ? 4'(OP_PREV_POT) : 4'd0;
  assign out_data   = (out_valid && !under_p0) ? 25'(rd_pot_p1) : 25'd0;

endmodule

// File: tb/tb_omem_potential_store.sv
// Scoreboard bench for omem_potential_store.
`timescale 1ns/1ps
module tb_omem_potential_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [24:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_dest;
  logic [3:0]  out_opcode;
  logic [24:0] out_data;
  logic        ts_done;
  logic [15:0] spike_cnt;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_bad_id;

  typedef struct {
    logic [3:0]  dest;
    logic [24:0] data;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  omem_potential_store dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_opcode(out_opcode), .out_data(out_data),
    .ts_done(ts_done), .spike_cnt(spike_cnt),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_bad_id(err_bad_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Responses are taken at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_dest", 32'(out_dest), 32'(e.dest));
        chk("resp_data", 32'(out_data), 32'(e.data));
        chk("resp_opcode", 32'(out_opcode), 32'd2);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [24:0] d, input logic ts,
                      output int cyc);
    bit ok;
    cyc = 0;
    in_valid = 1'b1; in_opcode = op; in_data = d; ts_done = ts;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      cyc++;
      ts_done = 1'b0;
    end while (!ok && cyc < 20);
    in_valid = 1'b0; ts_done = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input int id, input int pot, input bit spk, input bit ts = 1'b0);
    int c;
    send({3'(id), 1'b0}, {11'h5A5, 13'(pot), spk}, ts, c);
  endtask

  task automatic rd(input int id, input int pot);
    resp_t e;
    int c;
    e.dest = 4'((5 + id) % 16);
    e.data = 25'(pot);
    exp_q.push_back(e);
    send({3'(id), 1'b1}, 25'd0, 1'b0, c);
  endtask

  task automatic pulse_ts();
    ts_done = 1'b1;
    @(posedge clk); #1;
    ts_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c;
    logic [24:0] held_data;
    logic [3:0]  held_dest;
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_data = '0;
    out_ready = 1'b1; ts_done = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_dest", 32'(out_dest), 32'd0);
    chk("rst_spike_cnt", 32'(spike_cnt), 32'd0);
    chk("rst_errs", 32'({err_overflow, err_underflow, err_bad_id}), 32'd0);

    // Two writes to pe1, then read them back in order next timestep.
    wr(1, 70, 1'b1);
    chk("spike_after_w1", 32'(spike_cnt), 32'd1);
    wr(1, 5, 1'b0);
    chk("spike_after_w2", 32'(spike_cnt), 32'd1);
    pulse_ts();
    chk("spike_after_ts", 32'(spike_cnt), 32'd0);
    rd(1, 70);
    rd(1, 5);
    drain();

    // Interleaved SPEs keep independent FIFOs.
    wr(0, 10, 1'b0);
    wr(4, 20, 1'b0);
    wr(0, 30, 1'b0);
    pulse_ts();
    rd(0, 10);
    rd(4, 20);
    rd(0, 30);
    drain();

    // Back-pressure: outputs hold, input side stalls.
    wr(0, 123, 1'b0);
    pulse_ts();
    out_ready = 1'b0;
    rd(0, 123);
    wait_valid();
    held_data = out_data;
    held_dest = out_dest;
    chk("stall_data_val", 32'(held_data), 32'd123);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(held_data));
      chk("stall_dest", 32'(out_dest), 32'(held_dest));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("single_xfer", 32'(out_valid), 32'd0);

    // Overflow on DEPTH+1 writes, underflow on a read with nothing stored.
    for (int i = 0; i < 129; i++) begin
      wr(2, i, 1'b0);
      if (i == 127) chk("no_overflow_yet", 32'(err_overflow), 32'd0);
    end
    chk("overflow_set", 32'(err_overflow), 32'd1);
    chk("underflow_clear", 32'(err_underflow), 32'd0);
    rd(2, 0);
    drain();
    chk("underflow_set", 32'(err_underflow), 32'd1);
    pulse_ts();
    rd(2, 0);
    rd(2, 1);
    drain();

    // Bad SPE id is dropped without a response; next packet goes straight in.
    pulse_ts();
    send({3'd6, 1'b0}, {11'd0, 13'd77, 1'b1}, 1'b0, c);
    chk("bad_id_set", 32'(err_bad_id), 32'd1);
    chk("bad_id_no_spike", 32'(spike_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bad_id_no_resp", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send({3'd3, 1'b0}, {11'd0, 13'd11, 1'b0}, 1'b0, c);
    chk("next_accept_cycles", 32'(c), 32'd1);

    // ts_done on the same edge as a write: data stored, pointers roll over.
    wr(3, 22, 1'b0);
    wr(3, 9, 1'b1, 1'b1);
    chk("same_edge_spike", 32'(spike_cnt), 32'd0);
    rd(3, 11);
    rd(3, 22);
    rd(3, 0);
    drain();
    wr(3, 44, 1'b0);
    pulse_ts();
    rd(3, 44);
    drain();

    // Reset while a response is pending drops it.
    out_ready = 1'b0;
    send({3'd3, 1'b1}, 25'd0, 1'b0, c);
    wait_valid();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid_errs", 32'({err_overflow, err_underflow, err_bad_id}), 32'd0);
    rd(0, 0);
    drain();
    chk("post_rst_underflow", 32'(err_underflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
